// File: rtl/fetch_pkg.sv
// fetch_pkg: constants shared by the fetch queue, its buffer and the core front end.
package fetch_pkg;
    localparam int FQ_DEPTH = 4;
    localparam int FQ_PTR_W = $clog2(FQ_DEPTH);
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP = 32'h00000013;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, instruction-memory and decode-side handshake of the fetch queue.
interface fetch_queue_if #(parameter int WIDTH = 32);
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_pc4;
    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4
    );
    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4
    );
endinterface

// File: rtl/fq_fifo.sv
// fq_fifo: circular buffer with wrapping pointers and occupancy count; flush empties it.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            pushData,
    output logic [DW-1:0]            headData,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    assign headData = mem[rdPtr];
    // Storage is cleared on reset so the head reads as zero before the first word arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) mem[wrPtr] <= pushData;
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop) rdPtr <= rdPtr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with credit-limited fetch and redirect flush.
// Define FQ_BYPASS_EN to hand a response straight to decode when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               DEPTH    = FQ_DEPTH,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);
    logic [WIDTH-1:0] fpc, pcTag, outPc;
    logic [CW-1:0] outstanding, discard, count;
    logic [2*WIDTH-1:0] headData;
    logic rvOk, fire, deliver, bypass, consumed, push, pop, qValid;
    assign qValid = count != '0;
    assign rvOk = bus.imem_rvalid & (outstanding != '0);
    assign fire = bus.imem_req & bus.imem_gnt;
    assign deliver = rvOk & (discard == '0) & ~bus.redirect;
`ifdef FQ_BYPASS_EN
    assign bypass = deliver & ~qValid;
`else
    assign bypass = 1'b0;
`endif
    assign consumed = bypass & bus.out_ready;
    assign push = deliver & ~consumed;
    assign pop = qValid & bus.out_ready & ~bus.redirect;
    // Requests in flight plus words held never exceed DEPTH, so a push always finds room.
    assign bus.imem_req = reset & ~bus.redirect & (count + outstanding < CW'(DEPTH));
    assign bus.imem_addr = fpc;
    assign bus.out_valid = qValid | bypass;
    assign bus.out_instr = bypass ? bus.imem_rdata : headData[2*WIDTH-1:WIDTH];
    assign outPc = bypass ? pcTag : headData[WIDTH-1:0];
    assign bus.out_pc = outPc;
    assign bus.out_pc4 = outPc + STEP;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc         <= RESET_PC;
            pcTag       <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(rvOk);
            // Every request still in flight at a redirect belongs to the abandoned path.
            if (bus.redirect) begin
                fpc     <= bus.redirect_pc;
                pcTag   <= bus.redirect_pc;
                discard <= outstanding - CW'(rvOk);
            end else begin
                if (fire) fpc <= fpc + STEP;
                if (deliver) pcTag <= pcTag + STEP;
                if (rvOk && discard != '0) discard <= discard - CW'(1);
            end
        end
    end
    fq_fifo #(.DEPTH(DEPTH), .DW(2*WIDTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (bus.redirect),
        .push     (push),
        .pop      (pop),
        .pushData ({bus.imem_rdata, pcTag}),
        .headData (headData),
        .count    (count)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: cycle-by-cycle directed vectors for the fetch queue plus reset and bypass sequences.
module tb_fetch_queue;
    import fetch_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int fails = 0;
    int inflight;
    always #5 clk = ~clk;
    fetch_queue_if #(.WIDTH(32)) bus ();
    fetch_queue #(.DEPTH(4), .WIDTH(32), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdAddr;
        logic        rdy;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
    } vec_t;
    vec_t vt[$];
    function automatic logic [31:0] dOf(logic [31:0] a);
        return {a[15:0], 16'h0013} ^ 32'h0A000000;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic add(logic redir, logic [31:0] rpc, logic gnt, logic rv, logic [31:0] rdAddr, logic rdy,
                       logic eReq, logic [31:0] eAddr, logic eValid, logic [31:0] ePc);
        vt.push_back('{redir, rpc, gnt, rv, rdAddr, rdy, eReq, eAddr, eValid, ePc});
    endtask
    task automatic drive(logic redir, logic [31:0] rpc, logic gnt, logic rv, logic [31:0] rdata, logic rdy);
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rdata;
        bus.out_ready   = rdy;
    endtask
    // Memory protocol monitor: a response is only legal while a request is outstanding.
    always @(posedge clk or negedge reset) begin
        if (!reset) inflight <= 0;
        else begin
            if (bus.imem_rvalid) assert (inflight > 0) else $error("rvalid with no request in flight");
            inflight <= inflight + int'(bus.imem_req && bus.imem_gnt) - int'(bus.imem_rvalid);
        end
    end
    initial begin
        drive(0, 0, 0, 0, 0, 0);
        #12;
        chk("reset req", 32'(bus.imem_req), 0);
        chk("reset valid", 32'(bus.out_valid), 0);
        chk("reset instr", bus.out_instr, 0);
        chk("reset pc", bus.out_pc, 0);
        chk("reset pc4", bus.out_pc4, 32'h4);
        @(negedge clk);
        reset = 1'b1;
`ifdef FQ_BYPASS_EN
        @(negedge clk); drive(1, 32'h20, 0, 0, 0, 1); #3;
        chk("byp redirect req", 32'(bus.imem_req), 0);
        @(negedge clk); drive(0, 0, 1, 0, 0, 1); #3;
        chk("byp req", 32'(bus.imem_req), 1);
        chk("byp addr", bus.imem_addr, 32'h20);
        @(negedge clk); drive(0, 0, 0, 1, 32'h00500093, 1); #3;
        chk("byp valid", 32'(bus.out_valid), 1);
        chk("byp instr", bus.out_instr, 32'h00500093);
        chk("byp pc", bus.out_pc, 32'h20);
        chk("byp pc4", bus.out_pc4, 32'h24);
        @(negedge clk); drive(0, 0, 1, 0, 0, 0); #3;
        chk("byp consumed empty", 32'(bus.out_valid), 0);
        chk("byp addr2", bus.imem_addr, 32'h24);
        @(negedge clk); drive(0, 0, 0, 1, NOP, 0); #3;
        chk("byp stall valid", 32'(bus.out_valid), 1);
        chk("byp stall pc", bus.out_pc, 32'h24);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0); #3;
        chk("byp pushed valid", 32'(bus.out_valid), 1);
        chk("byp pushed instr", bus.out_instr, NOP);
        chk("byp pushed pc", bus.out_pc, 32'h24);
`else
        add(0, 0, 1, 0, 0, 0,            1, 32'h0, 0, 0);
        add(0, 0, 1, 1, 32'h0, 0,        1, 32'h4, 0, 0);
        add(0, 0, 1, 1, 32'h4, 0,        1, 32'h8, 1, 32'h0);
        add(0, 0, 1, 1, 32'h8, 0,        1, 32'hC, 1, 32'h0);
        add(0, 0, 1, 1, 32'hC, 0,        0, 32'h10, 1, 32'h0);
        add(0, 0, 1, 0, 0, 0,            0, 32'h10, 1, 32'h0);
        add(0, 0, 0, 0, 0, 1,            0, 32'h10, 1, 32'h0);
        add(0, 0, 1, 0, 0, 0,            1, 32'h10, 1, 32'h4);
        add(0, 0, 0, 1, 32'h10, 1,       0, 32'h14, 1, 32'h4);
        add(0, 0, 1, 0, 0, 1,            1, 32'h14, 1, 32'h8);
        add(0, 0, 1, 1, 32'h14, 1,       1, 32'h18, 1, 32'hC);
        add(0, 0, 0, 1, 32'h18, 0,       1, 32'h1C, 1, 32'h10);
        add(0, 0, 0, 0, 0, 0,            1, 32'h1C, 1, 32'h10);
        add(0, 0, 0, 0, 0, 0,            1, 32'h1C, 1, 32'h10);
        add(0, 0, 1, 0, 0, 0,            1, 32'h1C, 1, 32'h10);
        add(0, 0, 1, 0, 0, 0,            0, 32'h20, 1, 32'h10);
        add(0, 0, 0, 1, 32'h1C, 1,       0, 32'h20, 1, 32'h10);
        add(0, 0, 1, 0, 0, 1,            1, 32'h20, 1, 32'h14);
        add(0, 0, 1, 0, 0, 1,            1, 32'h24, 1, 32'h18);
        add(1, 32'h100, 1, 0, 0, 1,      0, 32'h28, 1, 32'h1C);
        add(0, 0, 1, 1, 32'h20, 0,       1, 32'h100, 0, 0);
        add(0, 0, 1, 1, 32'h24, 0,       1, 32'h104, 0, 0);
        add(0, 0, 0, 1, 32'h100, 0,      1, 32'h108, 0, 0);
        add(0, 0, 0, 0, 0, 0,            1, 32'h108, 1, 32'h100);
        add(0, 0, 1, 0, 0, 0,            1, 32'h108, 1, 32'h100);
        add(0, 0, 1, 0, 0, 0,            1, 32'h10C, 1, 32'h100);
        add(1, 32'h200, 1, 1, 32'h104, 0, 0, 32'h110, 1, 32'h100);
        add(0, 0, 0, 1, 32'h108, 0,      1, 32'h200, 0, 0);
        add(0, 0, 0, 1, 32'h10C, 0,      1, 32'h200, 0, 0);
        add(0, 0, 1, 0, 0, 0,            1, 32'h200, 0, 0);
        add(0, 0, 0, 1, 32'h200, 0,      1, 32'h204, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 32'h204, 1, 32'h200);
        add(0, 0, 1, 0, 0, 0,            1, 32'h204, 0, 0);
        add(1, 32'h300, 1, 0, 0, 0,      0, 32'h208, 0, 0);
        add(1, 32'h400, 0, 1, 32'h204, 0, 0, 32'h300, 0, 0);
        add(0, 0, 1, 0, 0, 0,            1, 32'h400, 0, 0);
        add(0, 0, 0, 1, 32'h400, 0,      1, 32'h404, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 32'h404, 1, 32'h400);
        add(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 32'h404, 0, 0);
        add(0, 0, 1, 0, 0, 0,            1, 32'hFFFFFFFC, 0, 0);
        add(0, 0, 0, 1, 32'hFFFFFFFC, 0, 1, 32'h0, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 32'h0, 1, 32'hFFFFFFFC);
        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].redir, vt[i].rpc, vt[i].gnt, vt[i].rv, dOf(vt[i].rdAddr), vt[i].rdy);
            #3;
            chk($sformatf("c%0d req", i), 32'(bus.imem_req), 32'(vt[i].eReq));
            chk($sformatf("c%0d addr", i), bus.imem_addr, vt[i].eAddr);
            chk($sformatf("c%0d valid", i), 32'(bus.out_valid), 32'(vt[i].eValid));
            if (vt[i].eValid) begin
                chk($sformatf("c%0d pc", i), bus.out_pc, vt[i].ePc);
                chk($sformatf("c%0d pc4", i), bus.out_pc4, vt[i].ePc + 32'h4);
                chk($sformatf("c%0d instr", i), bus.out_instr, dOf(vt[i].ePc));
            end
        end
        @(negedge clk); drive(0, 0, 1, 0, 0, 0);
        @(negedge clk); drive(0, 0, 1, 1, dOf(32'h0), 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0); #2;
        chk("pre-reset valid", 32'(bus.out_valid), 1);
        chk("pre-reset addr", bus.imem_addr, 32'h8);
        reset = 1'b0; #1;
        chk("mid reset req", 32'(bus.imem_req), 0);
        chk("mid reset valid", 32'(bus.out_valid), 0);
        chk("mid reset pc", bus.out_pc, 0);
        chk("mid reset pc4", bus.out_pc4, 32'h4);
        chk("mid reset addr", bus.imem_addr, 32'h0);
        @(negedge clk); reset = 1'b1; #3;
        chk("post reset req", 32'(bus.imem_req), 1);
        chk("post reset addr", bus.imem_addr, 32'h0);
`endif
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
